// File: rtl/fir_tap_sequencer_if.sv
// Bus between the FIR tap sequencer and the MAC / final-adder stages.
// The sequencer side uses the master modport.
interface fir_tap_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             iEnable;
    logic [WIDTH-1:0] iInSample;
    logic             oEnSample600k;
    logic             oMacClr;
    logic             oMacEn;
    logic [3:0]       oCoeffAddr;
    logic [WIDTH-1:0] oTap1;
    logic [WIDTH-1:0] oTap2;
    logic [WIDTH-1:0] oTap3;
    logic [WIDTH-1:0] oTap4;
    logic             oEnDelay;

    modport master (
        input  iEnable, iInSample,
        output oEnSample600k, oMacClr, oMacEn, oCoeffAddr,
        output oTap1, oTap2, oTap3, oTap4, oEnDelay
    );

    modport slave (
        output iEnable, iInSample,
        input  oEnSample600k, oMacClr, oMacEn, oCoeffAddr,
        input  oTap1, oTap2, oTap3, oTap4, oEnDelay
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR front end: sample strobe generation, input delay line and per-period
// sequencing of four parallel MACs (clear, accumulate, sum capture).
module fir_tap_sequencer #(
    parameter int DIV          = 20,
    parameter int TAPS_PER_MAC = 10,
    parameter int WIDTH        = 16
) (
    input  logic                 iClk12M,
    input  logic                 iRsn,
    fir_tap_sequencer_if.master  bus
);
    localparam int NTAPS = 4 * TAPS_PER_MAC;
    localparam int PW    = $clog2(DIV);

    typedef enum logic [2:0] {IDLE, CLEAR, ACC, SUM, WAIT} state_t;

    state_t           rState, nState;
    logic [PW-1:0]    rPhase, nPhase;
    logic [WIDTH-1:0] rDelay [NTAPS];

    logic             rStrobe, rClr, rEn, rEnDelay;
    logic [3:0]       rAddr, nAddr;
    logic [WIDTH-1:0] rTap [4];
    logic [WIDTH-1:0] nTap [4];

    // Outputs are registered from the next-state view, so each strobe is
    // high in the cycle whose rPhase matches its nominal phase number.
    always_comb begin
        nPhase = '0;
        if (bus.iEnable)
            nPhase = (rPhase == PW'(DIV - 1)) ? '0 : rPhase + PW'(1);

        nState = rState;
        if (!bus.iEnable) begin
            nState = IDLE;
        end else begin
            case (rState)
                IDLE:    if (rStrobe) nState = CLEAR;
                CLEAR:   nState = ACC;
                ACC:     if (rPhase == PW'(TAPS_PER_MAC)) nState = SUM;
                SUM:     nState = WAIT;
                WAIT:    if (rStrobe) nState = CLEAR;
                default: nState = IDLE;
            endcase
        end

        nAddr = '0;
        for (int unsigned n = 0; n < 4; n++) nTap[n] = '0;
        if (nState == ACC) begin
            nAddr = 4'(nPhase - PW'(1));
            for (int unsigned n = 0; n < 4; n++)
                nTap[n] = rDelay[n * TAPS_PER_MAC + int'(nAddr)];
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            rPhase   <= '0;
            rState   <= IDLE;
            rStrobe  <= 1'b0;
            rClr     <= 1'b0;
            rEn      <= 1'b0;
            rEnDelay <= 1'b0;
            rAddr    <= '0;
            for (int unsigned n = 0; n < 4; n++) rTap[n] <= '0;
            for (int unsigned k = 0; k < NTAPS; k++) rDelay[k] <= '0;
        end else begin
            rPhase   <= nPhase;
            rState   <= nState;
            rStrobe  <= (nPhase == PW'(DIV - 1));
            rClr     <= (nState == CLEAR);
            rEn      <= (nState == ACC);
            rEnDelay <= (nState == SUM);
            rAddr    <= nAddr;
            for (int unsigned n = 0; n < 4; n++) rTap[n] <= nTap[n];
            if (rStrobe) begin
                rDelay[0] <= bus.iInSample;
                for (int unsigned k = 1; k < NTAPS; k++) rDelay[k] <= rDelay[k-1];
            end
        end
    end

    assign bus.oEnSample600k = rStrobe;
    assign bus.oMacClr       = rClr;
    assign bus.oMacEn        = rEn;
    assign bus.oCoeffAddr    = rAddr;
    assign bus.oEnDelay      = rEnDelay;
    assign bus.oTap1         = rTap[0];
    assign bus.oTap2         = rTap[1];
    assign bus.oTap3         = rTap[2];
    assign bus.oTap4         = rTap[3];
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer against a cycle-count based
// reference model of the sample period and a queue model of the delay line.
module tb_fir_tap_sequencer;
    localparam int DIV = 20;
    localparam int T   = 10;
    localparam int W   = 16;
    localparam int NT  = 4 * T;

    logic iClk12M = 1'b0;
    logic iRsn    = 1'b1;

    fir_tap_sequencer_if #(.WIDTH(W)) ifc ();

    fir_tap_sequencer #(
        .DIV(DIV),
        .TAPS_PER_MAC(T),
        .WIDTH(W)
    ) dut (
        .iClk12M(iClk12M),
        .iRsn(iRsn),
        .bus(ifc)
    );

    always #5 iClk12M = ~iClk12M;

    int checks = 0;
    int errors = 0;

    // k: number of consecutive enabled cycles preceding the current cycle.
    int k = 0;
    int nStrobe = 0;
    logic [W-1:0] dq[$];

    logic [71:0] obsPack;
    assign obsPack = {ifc.oEnSample600k, ifc.oMacClr, ifc.oMacEn, ifc.oCoeffAddr,
                      ifc.oEnDelay, ifc.oTap1, ifc.oTap2, ifc.oTap3, ifc.oTap4};

    function automatic bit expStrobe();
        return (k % DIV) == DIV - 1;
    endfunction

    function automatic logic [71:0] expPack();
        int ph, a;
        logic s, c, e, d;
        logic [3:0] ad;
        logic [W-1:0] t [4];
        ph = k % DIV;
        s  = (ph == DIV - 1);
        c  = 1'b0; e = 1'b0; d = 1'b0; ad = '0;
        for (int n = 0; n < 4; n++) t[n] = '0;
        if (k >= DIV) begin
            c = (ph == 0);
            d = (ph == T + 1);
            if (ph >= 1 && ph <= T) begin
                e  = 1'b1;
                a  = ph - 1;
                ad = 4'(a);
                for (int n = 0; n < 4; n++) t[n] = dq[n * T + a];
            end
        end
        return {s, c, e, ad, d, t[0], t[1], t[2], t[3]};
    endfunction

    task automatic modelReset();
        k = 0;
        nStrobe = 0;
        dq.delete();
        repeat (NT) dq.push_back('0);
    endtask

    // Drives the inputs for the current cycle and advances the model past it.
    task automatic drive(input bit en, input logic [W-1:0] s);
        ifc.iEnable   = en;
        ifc.iInSample = s;
        if (expStrobe()) begin
            dq.push_front(s);
            void'(dq.pop_back());
            nStrobe++;
        end
        k = en ? k + 1 : 0;
    endtask

    task automatic test_reset();
        ifc.iEnable   = 1'b0;
        ifc.iInSample = '0;
        #1 iRsn = 1'b0;
        #1;
        checks++;
        if (obsPack !== '0) begin
            errors++;
            $display("FAIL reset_immediate got %h expected 0", obsPack);
        end
        ifc.iEnable = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge iClk12M);
            checks++;
            if (obsPack !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got %h expected 0", i, obsPack);
            end
            ifc.iInSample = W'($urandom);
        end
        @(negedge iClk12M);
        iRsn = 1'b1;
        modelReset();
        drive(1'b1, W'($urandom));
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 3 * DIV + 5; i++) begin
            @(negedge iClk12M);
            checks++;
            if (obsPack !== expPack()) begin
                errors++;
                $display("FAIL seq k=%0d got %h expected %h", k, obsPack, expPack());
            end
            if (k == 19 || k == 20 || k == 31) begin
                checks++;
                if ({ifc.oEnSample600k, ifc.oMacClr, ifc.oEnDelay} !==
                    {k == 19, k == 20, k == 31}) begin
                    errors++;
                    $display("FAIL seq_strobes k=%0d got %b%b%b", k,
                             ifc.oEnSample600k, ifc.oMacClr, ifc.oEnDelay);
                end
            end
            drive(1'b1, W'($urandom));
        end
    endtask

    task automatic test_taps();
        bit sawA0 = 1'b0;
        bit sawA9 = 1'b0;
        @(negedge iClk12M);
        iRsn = 1'b0;
        @(negedge iClk12M);
        iRsn = 1'b1;
        modelReset();
        drive(1'b1, W'(nStrobe + 1));
        for (int i = 0; i < 41 * DIV; i++) begin
            @(negedge iClk12M);
            checks++;
            if (obsPack !== expPack()) begin
                errors++;
                $display("FAIL taps k=%0d got %h expected %h", k, obsPack, expPack());
            end
            if (nStrobe == 40 && k % DIV == 1) begin
                sawA0 = 1'b1;
                checks++;
                if ({ifc.oTap1, ifc.oTap2, ifc.oTap3, ifc.oTap4} !==
                    {16'd40, 16'd30, 16'd20, 16'd10}) begin
                    errors++;
                    $display("FAIL taps_addr0 got %0d %0d %0d %0d expected 40 30 20 10",
                             ifc.oTap1, ifc.oTap2, ifc.oTap3, ifc.oTap4);
                end
            end
            if (nStrobe == 40 && k % DIV == T) begin
                sawA9 = 1'b1;
                checks++;
                if ({ifc.oTap1, ifc.oTap2, ifc.oTap3, ifc.oTap4} !==
                    {16'd31, 16'd21, 16'd11, 16'd1}) begin
                    errors++;
                    $display("FAIL taps_addr9 got %0d %0d %0d %0d expected 31 21 11 1",
                             ifc.oTap1, ifc.oTap2, ifc.oTap3, ifc.oTap4);
                end
            end
            drive(1'b1, W'(nStrobe + 1));
        end
        if (!sawA0 || !sawA9) begin
            checks++;
            errors++;
            $display("FAIL taps_timeout got a0=%0b a9=%0b expected 1 1", sawA0, sawA9);
        end
    endtask

    task automatic test_sign();
        int base = nStrobe;
        bit seen = 1'b0;
        logic [W-1:0] s;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge iClk12M);
            checks++;
            if (obsPack !== expPack()) begin
                errors++;
                $display("FAIL sign k=%0d got %h expected %h", k, obsPack, expPack());
            end
            if (nStrobe == base + 2 && (k % DIV == 1 || k % DIV == 2)) begin
                seen = 1'b1;
                checks++;
                if (ifc.oTap1 !== ((k % DIV == 1) ? 16'h7FFF : 16'h8000)) begin
                    errors++;
                    $display("FAIL sign_tap1 addr=%0d got %h", ifc.oCoeffAddr, ifc.oTap1);
                end
            end
            if (nStrobe == base)          s = 16'h8000;
            else if (nStrobe == base + 1) s = 16'h7FFF;
            else                          s = W'($urandom);
            drive(1'b1, s);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL sign_timeout got no addr0/1 window expected one");
        end
    endtask

    task automatic test_disable();
        bit dropped = 1'b0;
        int c;
        for (int i = 0; i < 2 * DIV && !dropped; i++) begin
            @(negedge iClk12M);
            checks++;
            if (obsPack !== expPack()) begin
                errors++;
                $display("FAIL dis_pre k=%0d got %h expected %h", k, obsPack, expPack());
            end
            if (k >= DIV && k % DIV == 5) begin
                dropped = 1'b1;
                drive(1'b0, W'($urandom));
            end else begin
                drive(1'b1, W'($urandom));
            end
        end
        if (!dropped) begin
            checks++;
            errors++;
            $display("FAIL dis_timeout got no addr4 cycle expected one");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk12M);
            checks++;
            if (obsPack !== '0) begin
                errors++;
                $display("FAIL dis_idle cyc=%0d got %h expected 0", i, obsPack);
            end
            drive(i == 3, W'($urandom));
        end
        c = 0;
        for (int i = 0; i < 2 * DIV + 5; i++) begin
            @(negedge iClk12M);
            c++;
            checks++;
            if (obsPack !== expPack()) begin
                errors++;
                $display("FAIL dis_resume k=%0d got %h expected %h", k, obsPack, expPack());
            end
            if (c == 19 || c == 20) begin
                checks++;
                if ({ifc.oEnSample600k, ifc.oMacClr} !== {c == 19, c == 20}) begin
                    errors++;
                    $display("FAIL dis_restart c=%0d got %b%b", c, ifc.oEnSample600k, ifc.oMacClr);
                end
            end
            drive(1'b1, W'($urandom));
        end
    endtask

    task automatic test_async_reset();
        bit hit = 1'b0;
        for (int i = 0; i < 2 * DIV && !hit; i++) begin
            @(negedge iClk12M);
            checks++;
            if (obsPack !== expPack()) begin
                errors++;
                $display("FAIL ares_pre k=%0d got %h expected %h", k, obsPack, expPack());
            end
            hit = (k >= DIV && k % DIV == 5);
            drive(1'b1, W'($urandom));
        end
        #3 iRsn = 1'b0;
        #1;
        checks++;
        if (obsPack !== '0 || !hit) begin
            errors++;
            $display("FAIL ares_immediate got %h hit=%0b expected 0 hit=1", obsPack, hit);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk12M);
            checks++;
            if (obsPack !== '0) begin
                errors++;
                $display("FAIL ares_hold cyc=%0d got %h expected 0", i, obsPack);
            end
        end
        iRsn = 1'b1;
        modelReset();
        drive(1'b1, W'($urandom));
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge iClk12M);
            checks++;
            if (obsPack !== expPack()) begin
                errors++;
                $display("FAIL ares_post k=%0d got %h expected %h", k, obsPack, expPack());
            end
            drive(1'b1, W'($urandom));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1200; i++) begin
            @(negedge iClk12M);
            checks++;
            if (obsPack !== expPack()) begin
                errors++;
                $display("FAIL rand k=%0d got %h expected %h", k, obsPack, expPack());
            end
            drive($urandom_range(0, 99) < 97, W'($urandom));
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_sequence();
        test_taps();
        test_sign();
        test_disable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
